// File: rtl/ex_cdb_arbiter.sv
// ex_cdb_arbiter
//   Shares the single CDB broadcast / PRF write port among the execute-stage
//   functional units. Every unit owns a one-entry holding slot; a round-robin
//   arbiter drains one full slot per cycle onto a registered CDB output.
//
// Ports
//   clock, reset       : clock and synchronous active-high reset
//   flush              : branch-mispredict squash, empties all slots
//   req_valid          : per-unit result valid
//   req_tag/data/rob_idx : per-unit result fields, unit i at [i*W +: W]
//   req_ready          : unit i may present a result this cycle
//   cdb_valid          : broadcast valid, high for exactly one cycle per grant
//   cdb_tag/data/rob_idx : broadcast payload
//   cdb_src            : one-hot source unit of the current broadcast
module ex_cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 6,
    parameter int ROB_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*ROB_W-1:0]  req_rob_idx,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [ROB_W-1:0]          cdb_rob_idx,
    output logic [NUM_REQ-1:0]        cdb_src
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] slot_full_q, slot_full_d;
    logic [TAG_W-1:0]   slot_tag_q  [NUM_REQ];
    logic [TAG_W-1:0]   slot_tag_d  [NUM_REQ];
    logic [DATA_W-1:0]  slot_data_q [NUM_REQ];
    logic [DATA_W-1:0]  slot_data_d [NUM_REQ];
    logic [ROB_W-1:0]   slot_rob_q  [NUM_REQ];
    logic [ROB_W-1:0]   slot_rob_d  [NUM_REQ];

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [ROB_W-1:0]   cdb_rob_q, cdb_rob_d;
    logic [NUM_REQ-1:0] cdb_src_q, cdb_src_d;

    logic [NUM_REQ-1:0] grant;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] accept;

    // Round-robin search: first full slot at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_vld && slot_full_q[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

    // A granted slot drains this cycle, so it can take a new result at the
    // same edge; this is what allows one result per cycle per unit.
    assign req_ready = ~{NUM_REQ{flush}} & (~slot_full_q | grant);
    assign accept    = req_valid & req_ready;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_tag_d[i]  = slot_tag_q[i];
            slot_data_d[i] = slot_data_q[i];
            slot_rob_d[i]  = slot_rob_q[i];
            if (flush) begin
                slot_full_d[i] = 1'b0;
            end else if (accept[i]) begin
                slot_full_d[i] = 1'b1;
                slot_tag_d[i]  = req_tag[i*TAG_W +: TAG_W];
                slot_data_d[i] = req_data[i*DATA_W +: DATA_W];
                slot_rob_d[i]  = req_rob_idx[i*ROB_W +: ROB_W];
            end else if (grant[i]) begin
                slot_full_d[i] = 1'b0;
            end else begin
                slot_full_d[i] = slot_full_q[i];
            end
        end
    end

    // A grant computed during flush is dropped: no broadcast, pointer kept.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = grant_vld & ~flush;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_rob_d   = cdb_rob_q;
        cdb_src_d   = cdb_src_q;
        if (grant_vld && !flush) begin
            rr_ptr_d   = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
            cdb_tag_d  = slot_tag_q[grant_idx];
            cdb_data_d = slot_data_q[grant_idx];
            cdb_rob_d  = slot_rob_q[grant_idx];
            cdb_src_d  = grant;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_full_q <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_rob_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            slot_full_q <= slot_full_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // Slot payload is qualified by slot_full, so it needs no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_tag_q[i]  <= slot_tag_d[i];
            slot_data_q[i] <= slot_data_d[i];
            slot_rob_q[i]  <= slot_rob_d[i];
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_tag     = cdb_tag_q;
    assign cdb_data    = cdb_data_q;
    assign cdb_rob_idx = cdb_rob_q;
    assign cdb_src     = cdb_src_q;

endmodule
